gauss_filter_3x3: RTL and testbench



---
 rtl/gauss_pkg.sv | 11 +
 rtl/gauss_line_buffer.sv | 24 ++
 rtl/gauss_filter_3x3.sv | 94 +++++++++
 tb/tb_gauss_filter_3x3.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// gauss_pkg: shared constants and pixel type for the 3x3 Gaussian filter
package gauss_pkg;
  localparam int DATA_W = 8;
  localparam int LATENCY = 3;
  localparam int W_CORNER = 1;
  localparam int W_EDGE = 2;
  localparam int W_CENTRE = 4;
  localparam int RND = 8;
  localparam int SHIFT = 4;
  typedef logic [DATA_W-1:0] pix_t;
endpackage

// File: rtl/gauss_line_buffer.sv
// gauss_line_buffer: DEPTH-deep pixel delay line, advanced only when en is high
module gauss_line_buffer #(
  parameter int DEPTH = 1280,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  // read-before-write at the same slot yields the sample from DEPTH writes ago
  assign dout = mem[ptr];
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
  end
endmodule

// File: rtl/gauss_filter_3x3.sv
// gauss_filter_3x3: streaming [1 2 1;2 4 2;1 2 1]/16 filter with replicate-clamp edges
module gauss_filter_3x3 #(
  parameter int IMG_WIDTH = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int DATA_W = gauss_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_img_vsync,
  input  logic              pre_img_hsync,
  input  logic              pre_img_valid,
  input  logic [DATA_W-1:0] pre_img_data,
  output logic              post_img_vsync,
  output logic              post_img_hsync,
  output logic              post_img_valid,
  output logic [DATA_W-1:0] post_img_data
);
  import gauss_pkg::*;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int VW = DATA_W + 2;
  localparam int SW = DATA_W + 5;
  logic [LATENCY-1:0] vs_d, hs_d, va_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DATA_W-1:0] lb1_q, lb2_q, top, mid;
  logic [VW-1:0] vn, v0, v1;
  logic first1, last1;
  logic [SW-1:0] sum;
  logic vs_rise, va_fall;

  gauss_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(pre_img_valid), .din(pre_img_data), .dout(lb1_q)
  );
  gauss_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_W)) u_lb2 (
    .clk(clk), .rst(rst), .en(pre_img_valid), .din(lb1_q), .dout(lb2_q)
  );

  // rows above the frame top replicate row 0; the live input is always the bottom tap
  always_comb begin
    vs_rise = pre_img_vsync & ~vs_d[0];
    va_fall = ~pre_img_valid & va_d[0];
    top = (row == '0) ? pre_img_data : (row == RW'(1)) ? lb1_q : lb2_q;
    mid = (row == '0) ? pre_img_data : lb1_q;
    vn = VW'(W_CORNER) * VW'(top) + VW'(W_EDGE) * VW'(mid) + VW'(W_CORNER) * VW'(pre_img_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= '0;
      hs_d <= '0;
      va_d <= '0;
    end else begin
      vs_d <= {vs_d[LATENCY-2:0], pre_img_vsync};
      hs_d <= {hs_d[LATENCY-2:0], pre_img_hsync};
      va_d <= {va_d[LATENCY-2:0], pre_img_valid};
    end
  end

  assign post_img_vsync = vs_d[LATENCY-1];
  assign post_img_hsync = hs_d[LATENCY-1];
  assign post_img_valid = va_d[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst || vs_rise) begin
      col <= '0;
      row <= '0;
    end else begin
      if (pre_img_valid) col <= (col == CW'(IMG_WIDTH-1)) ? '0 : col + CW'(1);
      else if (va_fall) col <= '0;
      if (va_fall && row != RW'(IMG_HEIGHT-1)) row <= row + RW'(1);
    end
  end

  // column c+1 is taken live from the input so the result lands 3 clocks after column c
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= '0;
      v1 <= '0;
      first1 <= 1'b0;
      last1 <= 1'b0;
      sum <= '0;
      post_img_data <= '0;
    end else begin
      v1 <= vn;
      v0 <= v1;
      first1 <= col == '0;
      last1 <= col == CW'(IMG_WIDTH-1);
      sum <= SW'(W_CORNER) * SW'(first1 ? v1 : v0) + SW'(W_EDGE) * SW'(v1)
           + SW'(W_CORNER) * SW'(last1 ? v1 : vn) + SW'(RND);
      post_img_data <= va_d[LATENCY-2] ? DATA_W'(sum >> SHIFT) : '0;
    end
  end
endmodule

// File: tb/tb_gauss_filter_3x3.sv
// tb_gauss_filter_3x3: random and pattern frames checked against a whole-image convolution model
module tb_gauss_filter_3x3;
  import gauss_pkg::*;
  localparam int W = 15;
  localparam int H = 15;
  localparam int N = W * H;
  logic clk = 0, rst = 1, vs = 0, hs = 0, va = 0;
  logic [7:0] d = 0;
  logic pvs, phs, pva;
  logic [7:0] pd;
  int vectors = 0, miscompares = 0;
  pix_t img [H][W];
  pix_t expv [H][W];
  pix_t got [N];
  bit chk_en = 0;
  int oidx = 0;
  logic pvs_q = 0;
  logic [2:0] h1 = 0, h2 = 0, h3 = 0;

  always #5 clk = ~clk;

  gauss_filter_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(va), .pre_img_data(d),
    .post_img_vsync(pvs), .post_img_hsync(phs), .post_img_valid(pva), .post_img_data(pd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (out index %0d, t=%0t)", name, act, req, oidx, $time);
    end
  endtask

  // output row k uses input rows k-2..k (clamped to 0) and columns c-1..c+1 (clamped)
  task automatic model();
    for (int k = 0; k < H; k++)
      for (int c = 0; c < W; c++) begin
        int acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = -1; j <= 1; j++) begin
            int r = (k - 2 + i < 0) ? 0 : k - 2 + i;
            int cc = (c + j < 0) ? 0 : (c + j > W - 1) ? W - 1 : c + j;
            acc += (i == 1 ? 2 : 1) * (j == 0 ? 2 : 1) * int'(img[r][cc]);
          end
        expv[k][c] = 8'((acc + 8) >> 4);
      end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = kind == 0 ? 8'h80 : kind == 1 ? ((r == 5 && c == 5) ? 8'hFF : 8'h00) :
                    kind == 2 ? 8'(c * 16) : kind == 4 ? 8'hFF : 8'($urandom);
  endtask

  task automatic cyc(input bit v_s, input bit h_s, input bit v_a, input logic [7:0] px);
    @(posedge clk);
    #1;
    vs = v_s;
    hs = h_s;
    va = v_a;
    d = v_a ? px : 8'($urandom);
  endtask

  task automatic run_frame();
    model();
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int r = 0; r < H; r++) begin
      cyc(0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0);
      for (int c = 0; c < W; c++) cyc(0, 0, 1, img[r][c]);
      repeat (3) cyc(0, 0, 0, 0);
    end
    repeat (4) cyc(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sync_delay", {pvs, phs, pva}, h3);
      if (!pva) check("idle_data", pd, 0);
    end
    if (pvs && !pvs_q) oidx = 0;
    if (pva) begin
      if (chk_en && oidx < N) check("pixel", pd, expv[oidx / W][oidx % W]);
      if (oidx < N) got[oidx] = pd;
      oidx++;
    end
    pvs_q = pvs;
    h3 = h2;
    h2 = h1;
    h1 = {vs, hs, va};
  end

  task automatic check_impulse();
    int ik[9] = '{6, 6, 6, 5, 7, 5, 5, 7, 7};
    int ic[9] = '{5, 4, 6, 5, 5, 4, 6, 4, 6};
    int iv[9] = '{64, 32, 32, 32, 32, 16, 16, 16, 16};
    int nz = 0;
    for (int i = 0; i < 9; i++) begin
      check("imp_model", expv[ik[i]][ic[i]], iv[i]);
      check("imp_dut", got[ik[i] * W + ic[i]], iv[i]);
    end
    for (int i = 0; i < N; i++) nz += (got[i] != 0) ? 1 : 0;
    check("imp_nonzero", nz, 9);
    check("imp_count", oidx, N);
  endtask

  task automatic check_all(input string name, input int v);
    int bad = 0;
    for (int i = 0; i < N; i++) bad += (got[i] != 8'(v)) ? 1 : 0;
    check(name, bad, 0);
    check("corner_tl", got[0], v);
    check("corner_br", got[N - 1], v);
    check("frame_count", oidx, N);
  endtask

  initial begin
    repeat (5) cyc(0, 0, 0, 0);
    @(negedge clk);
    check("reset_state", {pvs, phs, pva, pd}, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (5) cyc(0, 0, 0, 0);
    chk_en = 1;
    fill(0);
    run_frame();
    check_all("flat", 8'h80);
    fill(1);
    run_frame();
    check_impulse();
    fill(2);
    run_frame();
    for (int k = 0; k < H; k += 7) begin
      check("ramp_col0", got[k * W], 8'h04);
      check("ramp_col7", got[k * W + 7], 8'h70);
      check("ramp_col14", got[k * W + 14], 8'hDC);
    end
    check("ramp_model14", expv[3][14], 8'hDC);
    repeat (2) begin
      fill(3);
      run_frame();
      check("rand_count", oidx, N);
    end
    fill(4);
    run_frame();
    check_all("all_ff", 8'hFF);
    fill(3);
    fork
      run_frame();
      begin
        repeat (60) @(posedge clk);
        #1;
        rst = 1;
        chk_en = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {pvs, phs, pva, pd}, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rst_held", {pvs, phs, pva, pd}, 0);
        @(posedge clk);
        #1 rst = 0;
      end
    join
    repeat (5) cyc(0, 0, 0, 0);
    chk_en = 1;
    fill(0);
    run_frame();
    check_all("post_rst_flat", 8'h80);
    fill(1);
    run_frame();
    check_impulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
